ripple_ide_timed: RTL and testbench
===================================

Name: ripple_ide_timed

Overview:
- Next-generation IDE bus engine for the RIPPLE Zorro II card. It sits between the Autoconfig block and the IDE connectors.
- Decodes the board window into a ROM region, a mode register and up to two IDE channels.
- Generates its own DTACK/OVR with a clocked setup/strobe/recovery state machine. The mode register programs PIO timing at run time.
- Replaces the previous free-running decode, which had no generated DTACK, one channel and fixed timing.

Parameters:
- NUM_CHANNELS, 2, number of IDE channels (1 or 2); CS outputs are this wide.
- SETUP_CYC, 1, CLK cycles from CS assertion to strobe assertion (≥1).
- STROBE_CYC, 4, strobe low cycles at mode 0 (≥4).
- RECOVERY_CYC, 2, cycles after strobe release before a new cycle may start (≥1).

Ports:
- CLK  in  1  7 MHz bus clock (CLK7M); all sequential logic on rising edge.
- RESET_n  in  1  reset; asynchronous, active-low.
- ADDR  in  23  68000 address [23:1].
- AS_n  in  1  address strobe.
- UDS_n  in  1  upper data strobe.
- LDS_n  in  1  lower data strobe.
- RW  in  1  1 = read.
- BERR_n  in  1  bus error.
- ide_access  in  1  board window hit from Autoconfig.
- IDE_OFF_n  in  1  jumper; low disables the block.
- DIN  in  4  DBUS[15:12] write data.
- DOUT  out  4  mode register read data.
- DOUT_OE  out  1  drive DBUS[15:12] with DOUT.
- DTACK_OE  out  1  drive DTACK_n low (tristate in top level).
- OVR_OE  out  1  drive OVR_n low.
- IOR_n  out  1  IDE read strobe.
- IOW_n  out  1  IDE write strobe.
- IDECS1_n  out  NUM_CHANNELS  CS1 per channel.
- IDECS2_n  out  NUM_CHANNELS  CS2 per channel.
- IDE_ROMEN  out  1  ROM enable, active high.
- IDEBUF_OE  out  1  data buffer enable, active low.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (RESET_n low, async):
  - state = IDLE; mode = 0; rom_off = 0.
  - enable latches IDE_OFF_n continuously while reset is low and holds it after release.
  - Outputs during reset: all CS, IOR_n, IOW_n high; DTACK_OE, OVR_OE, DOUT_OE low; IDEBUF_OE high; IDE_ROMEN high; busy low.
- Decode on ADDR[16:15]:
  - 00: ROM, read-only.
  - 01: mode register.
  - 10: channel 0.
  - 11: channel 1. When NUM_CHANNELS=1 this is ignored: no DTACK, no CS, the bus times out.
  - Within a channel: ADDR[12]=0 selects CS1, ADDR[12]=1 selects CS2.
- start condition: enable && ide_access && !AS_n && BERR_n && (RW || !UDS_n || !LDS_n), sampled at a rising edge in IDLE.
- FSM states: IDLE, SETUP, STROBE, ACK, HOLD, RECOVER.
  - IDLE → on start:
    - IDE target: SETUP, counter = SETUP_CYC-1.
    - ROM or register target: ACK. A register write latches DIN at this edge: mode = DIN[1:0], rom_off = DIN[3].
  - SETUP: CS held low; when counter = 0 → STROBE, counter = strobe_len-1.
    - strobe_len = STROBE_CYC - mode, computed in unsigned width with a floor of 1.
  - STROBE: IOR_n (RW=1) or IOW_n (RW=0) low; when counter = 0 → ACK.
  - ACK: DTACK_OE=1; IOR_n stays low on reads. Next edge → HOLD.
  - HOLD: DTACK_OE=1 until AS_n is sampled high.
    - IDE target → RECOVER with counter = RECOVERY_CYC-1, strobe released on the same edge.
    - Otherwise → IDLE.
  - RECOVER: CS and strobes high; when counter = 0 → IDLE.
- Output timing: CS, strobes and DTACK_OE are registered, and each is a function of state and target only.
- OVR_OE = DTACK_OE | (busy & target ≠ none).
- IDEBUF_OE is low while busy and BERR_n high.
- DOUT = {rom_off, 1'b0, mode}. DOUT_OE = (state ∈ {ACK, HOLD}) && RW && target = register.
- IDE_ROMEN = enable && !rom_off.
- Aborts:
  - AS_n high in SETUP or STROBE → RECOVER for IDE targets, or IDLE otherwise. No DTACK is issued.
  - BERR_n low in any state → same abort path; DTACK_OE is forced 0 immediately (combinational gating).
- Minimum IDE latency with defaults, counting edges from the start edge: CS low at edge 0, strobe low at edge 1, DTACK at edge 5.
- A new start is ignored until IDLE; back-to-back cycles are separated by at least RECOVERY_CYC cycles.
- Mode register values 0–3 are all legal; bit 2 is reserved: writes are ignored and it reads 0.

Test Plan:
- Reset with IDE_OFF_n=0, then an IDE read at ADDR 0x010000 → no CS, DTACK_OE stays 0, IDE_ROMEN=0, busy=0.
- Defaults, channel 0 CS1 read:
  - IDECS1_n[0] low from edge 0; IOR_n low edges 1–4 and held through HOLD; DTACK_OE high at edge 5.
  - After AS_n rises: RECOVER 2 cycles, then IDLE.
- Write 4'b0011 to the mode register, then a channel 1 CS2 write → IOW_n low exactly 1 cycle (4-3); read-back DOUT = 4'b0011.
- Write 4'b1000 to the mode register → IDE_ROMEN goes low after the ACK edge; a ROM read still gets DTACK on the next cycle.
- BERR_n pulled low during STROBE → DTACK_OE stays 0, strobe released, RECOVER, IDLE; the next access proceeds normally.
- RESET_n asserted mid-STROBE → all outputs return to their reset values asynchronously; mode returns to 0.

Source files
------------

// File: rtl/ripple_ide_timed.sv
// RIPPLE Zorro II IDE bus engine: window decode, mode register and
// clocked PIO setup/strobe/recovery sequencer with generated DTACK/OVR.
module ripple_ide_timed #(
  parameter int NUM_CHANNELS = 2,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int RECOVERY_CYC = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic [23:1]             ADDR,
  input  logic                    AS_n,
  input  logic                    UDS_n,
  input  logic                    LDS_n,
  input  logic                    RW,
  input  logic                    BERR_n,
  input  logic                    ide_access,
  input  logic                    IDE_OFF_n,
  input  logic [3:0]              DIN,
  output logic [3:0]              DOUT,
  output logic                    DOUT_OE,
  output logic                    DTACK_OE,
  output logic                    OVR_OE,
  output logic                    IOR_n,
  output logic                    IOW_n,
  output logic [NUM_CHANNELS-1:0] IDECS1_n,
  output logic [NUM_CHANNELS-1:0] IDECS2_n,
  output logic                    IDE_ROMEN,
  output logic                    IDEBUF_OE,
  output logic                    busy
);

  localparam int CW = 8;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] REC_LD   = CW'(RECOVERY_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_ACK, S_HOLD, S_RECOVER
  } state_t;

  typedef enum logic [1:0] {
    T_NONE, T_ROM, T_REG, T_IDE
  } tgt_t;

  state_t        r_state, w_state_nx, w_abort_st;
  tgt_t          r_tgt, w_tgt;
  logic          r_ch, r_cs2, r_rw;
  logic          r_enable, r_rom_off;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_strobe_len;
  logic          w_start, w_load, w_abort;
  logic          w_dtack, w_cs_act;
  logic          w_unused;

  assign w_unused = ^{ADDR[23:17], ADDR[14:13], ADDR[11:1]};

  always_comb begin
    w_tgt = T_NONE;
    unique case (ADDR[16:15])
      2'b00:   w_tgt = T_ROM;
      2'b01:   w_tgt = T_REG;
      2'b10:   w_tgt = T_IDE;
      default: w_tgt = (NUM_CHANNELS > 1) ? T_IDE : T_NONE;
    endcase
  end

  assign w_start = r_enable & ide_access & ~AS_n & BERR_n &
                   (RW | ~UDS_n | ~LDS_n) & (w_tgt != T_NONE);
  assign w_load  = (r_state == S_IDLE) & w_start;
  assign w_abort = ~BERR_n | AS_n;

  // Faster modes shorten the strobe, never below one cycle
  assign w_strobe_len = (STROBE_CYC > int'(r_mode)) ?
                        CW'(STROBE_CYC - int'(r_mode)) : CW'(1);

  assign w_abort_st = (r_tgt == T_IDE) ? S_RECOVER : S_IDLE;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_tgt == T_IDE) begin
            w_state_nx = S_SETUP;
            w_cnt_nx   = SETUP_LD;
          end else begin
            w_state_nx = S_ACK;
          end
        end
      end
      S_SETUP: begin
        if (w_abort) begin
          w_state_nx = w_abort_st;
          w_cnt_nx   = REC_LD;
        end else if (r_cnt == '0) begin
          w_state_nx = S_STROBE;
          w_cnt_nx   = w_strobe_len - CW'(1);
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (w_abort) begin
          w_state_nx = w_abort_st;
          w_cnt_nx   = REC_LD;
        end else if (r_cnt == '0) begin
          w_state_nx = S_ACK;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_ACK: begin
        w_state_nx = S_HOLD;
        if (!BERR_n) begin
          w_state_nx = w_abort_st;
          w_cnt_nx   = REC_LD;
        end
      end
      S_HOLD: begin
        if (w_abort) begin
          w_state_nx = w_abort_st;
          w_cnt_nx   = REC_LD;
        end
      end
      S_RECOVER: begin
        if (r_cnt == '0) w_state_nx = S_IDLE;
        else             w_cnt_nx   = r_cnt - CW'(1);
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_tgt <= T_NONE;
      r_ch  <= 1'b0;
      r_cs2 <= 1'b0;
      r_rw  <= 1'b1;
    end else if (w_load) begin
      r_tgt <= w_tgt;
      r_ch  <= ADDR[15];
      r_cs2 <= ADDR[12];
      r_rw  <= RW;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_mode    <= 2'b00;
      r_rom_off <= 1'b0;
    end else if (w_load && w_tgt == T_REG && !RW) begin
      r_mode    <= DIN[1:0];
      r_rom_off <= DIN[3];
    end
  end

  // Jumper is tracked only while reset is held
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) r_enable <= IDE_OFF_n;
  end

  assign w_dtack  = (r_state == S_ACK) | (r_state == S_HOLD);
  assign w_cs_act = (r_tgt == T_IDE) & (r_state != S_IDLE) &
                    (r_state != S_RECOVER);

  always_comb begin
    IDECS1_n = '1;
    IDECS2_n = '1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_cs_act && int'(r_ch) == i) begin
        IDECS1_n[i] = r_cs2;
        IDECS2_n[i] = ~r_cs2;
      end
    end
  end

  assign IOR_n = ~((r_tgt == T_IDE) & r_rw &
                   ((r_state == S_STROBE) | w_dtack));
  assign IOW_n = ~((r_tgt == T_IDE) & ~r_rw & (r_state == S_STROBE));

  assign busy      = (r_state != S_IDLE);
  assign DTACK_OE  = w_dtack & BERR_n;
  assign OVR_OE    = DTACK_OE | (busy & (r_tgt != T_NONE));
  assign IDEBUF_OE = ~(busy & BERR_n);
  assign DOUT      = {r_rom_off, 1'b0, r_mode};
  assign DOUT_OE   = w_dtack & RW & (r_tgt == T_REG);
  assign IDE_ROMEN = ~RESET_n | (r_enable & ~r_rom_off);

endmodule

// File: tb/tb_ripple_ide_timed.sv
// Directed bench for ripple_ide_timed: decode, PIO timing, mode register,
// ROM disable, bus-error abort and asynchronous reset.
module tb_ripple_ide_timed;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [23:1] ADDR;
  logic        AS_n, UDS_n, LDS_n, RW, BERR_n;
  logic        ide_access, IDE_OFF_n;
  logic [3:0]  DIN;
  logic [3:0]  DOUT;
  logic        DOUT_OE, DTACK_OE, OVR_OE, IOR_n, IOW_n;
  logic [1:0]  IDECS1_n, IDECS2_n;
  logic        IDE_ROMEN, IDEBUF_OE, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] outs;
  logic [3:0]  cs;
  assign outs = {IDECS1_n, IDECS2_n, IOR_n, IOW_n, DTACK_OE, OVR_OE,
                 DOUT_OE, IDEBUF_OE, IDE_ROMEN, busy};
  assign cs   = {IDECS1_n, IDECS2_n};

  localparam logic [11:0] RST_OUTS = 12'b1111_1100_0110;

  ripple_ide_timed dut (
    .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .AS_n(AS_n),
    .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW), .BERR_n(BERR_n),
    .ide_access(ide_access), .IDE_OFF_n(IDE_OFF_n), .DIN(DIN),
    .DOUT(DOUT), .DOUT_OE(DOUT_OE), .DTACK_OE(DTACK_OE),
    .OVR_OE(OVR_OE), .IOR_n(IOR_n), .IOW_n(IOW_n),
    .IDECS1_n(IDECS1_n), .IDECS2_n(IDECS2_n), .IDE_ROMEN(IDE_ROMEN),
    .IDEBUF_OE(IDEBUF_OE), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    ide_access = 1'b0; RW = 1'b1;
  endtask

  task automatic next_edge();
    @(posedge CLK); #1;
  endtask

  task automatic begin_access(input logic [23:0] ba, input logic rw,
                              input logic [3:0] din);
    @(negedge CLK);
    ADDR = ba[23:1]; RW = rw; DIN = din;
    AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; ide_access = 1'b1;
    next_edge();
  endtask

  task automatic end_access();
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 20 && busy; k++) next_edge();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_idle_timeout: got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    bus_idle(); BERR_n = 1'b1; DIN = 4'h0; ADDR = '0;
    IDE_OFF_n = 1'b0; RESET_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (outs !== RST_OUTS) begin
      n_errors++;
      $display("FAIL rst_outs: got %b want %b", outs, RST_OUTS);
    end
    n_checks++;
    if (DOUT !== 4'h0) begin
      n_errors++;
      $display("FAIL rst_dout: got %h want 0", DOUT);
    end
    @(negedge CLK) RESET_n = 1'b1;
    next_edge();
    n_checks++;
    if (IDE_ROMEN !== 1'b0) begin
      n_errors++;
      $display("FAIL off_romen: got %b want 0", IDE_ROMEN);
    end
    begin_access(24'h010000, 1'b1, 4'h0);
    for (int e = 0; e < 8; e++) begin
      n_checks++;
      if ({cs, DTACK_OE, busy} !== 6'b111100) begin
        n_errors++;
        $display("FAIL off_access e%0d: got %b want 111100",
                 e, {cs, DTACK_OE, busy});
      end
      next_edge();
    end
    end_access();
    RESET_n = 1'b0; IDE_OFF_n = 1'b1;
    @(posedge CLK);
    @(negedge CLK) RESET_n = 1'b1;
    #1;
    n_checks++;
    if (IDE_ROMEN !== 1'b1) begin
      n_errors++;
      $display("FAIL on_romen: got %b want 1", IDE_ROMEN);
    end
  endtask

  task automatic test_ch0_read();
    begin_access(24'h010000, 1'b1, 4'h0);
    n_checks++;
    if ({cs, IOR_n, busy, OVR_OE, IDEBUF_OE} !== 8'b1011_1110) begin
      n_errors++;
      $display("FAIL rd_e0: got %b want 10111110",
               {cs, IOR_n, busy, OVR_OE, IDEBUF_OE});
    end
    for (int e = 1; e <= 4; e++) begin
      next_edge();
      n_checks++;
      if ({cs, IOR_n, DTACK_OE} !== 6'b1011_00) begin
        n_errors++;
        $display("FAIL rd_strobe e%0d: got %b want 101100",
                 e, {cs, IOR_n, DTACK_OE});
      end
    end
    for (int e = 5; e <= 6; e++) begin
      next_edge();
      n_checks++;
      if ({cs, IOR_n, DTACK_OE} !== 6'b1011_01) begin
        n_errors++;
        $display("FAIL rd_ack e%0d: got %b want 101101",
                 e, {cs, IOR_n, DTACK_OE});
      end
    end
    end_access();
    for (int e = 7; e <= 8; e++) begin
      next_edge();
      n_checks++;
      if ({cs, IOR_n, DTACK_OE, busy} !== 7'b1111_101) begin
        n_errors++;
        $display("FAIL rd_recover e%0d: got %b want 1111101",
                 e, {cs, IOR_n, DTACK_OE, busy});
      end
    end
    next_edge();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_mode_ch1_write();
    begin_access(24'h008000, 1'b0, 4'b0111);
    n_checks++;
    if ({DTACK_OE, DOUT_OE, busy, cs} !== 7'b101_1111) begin
      n_errors++;
      $display("FAIL regwr_e0: got %b want 1011111",
               {DTACK_OE, DOUT_OE, busy, cs});
    end
    end_access();
    wait_idle("regwr");
    n_checks++;
    if (DOUT !== 4'b0011) begin
      n_errors++;
      $display("FAIL regwr_dout: got %b want 0011", DOUT);
    end
    begin_access(24'h019000, 1'b0, 4'h0);
    n_checks++;
    if ({cs, IOW_n} !== 5'b1101_1) begin
      n_errors++;
      $display("FAIL wr_e0: got %b want 11011", {cs, IOW_n});
    end
    next_edge();
    n_checks++;
    if ({cs, IOW_n, IOR_n, DTACK_OE} !== 7'b1101_010) begin
      n_errors++;
      $display("FAIL wr_e1: got %b want 1101010",
               {cs, IOW_n, IOR_n, DTACK_OE});
    end
    next_edge();
    n_checks++;
    if ({cs, IOW_n, DTACK_OE} !== 6'b1101_11) begin
      n_errors++;
      $display("FAIL wr_e2: got %b want 110111", {cs, IOW_n, DTACK_OE});
    end
    end_access();
    wait_idle("wr");
    begin_access(24'h008000, 1'b1, 4'h0);
    n_checks++;
    if ({DOUT_OE, DOUT, DTACK_OE} !== 6'b1_0011_1) begin
      n_errors++;
      $display("FAIL regrd: got %b want 100111", {DOUT_OE, DOUT, DTACK_OE});
    end
    end_access();
    wait_idle("regrd");
    n_checks++;
    if (DOUT_OE !== 1'b0) begin
      n_errors++;
      $display("FAIL regrd_oe_off: got %b want 0", DOUT_OE);
    end
  endtask

  task automatic test_rom_off();
    n_checks++;
    if (IDE_ROMEN !== 1'b1) begin
      n_errors++;
      $display("FAIL romen_before: got %b want 1", IDE_ROMEN);
    end
    begin_access(24'h008000, 1'b0, 4'b1000);
    n_checks++;
    if ({IDE_ROMEN, DOUT} !== 5'b0_1000) begin
      n_errors++;
      $display("FAIL romoff: got %b want 01000", {IDE_ROMEN, DOUT});
    end
    end_access();
    wait_idle("romoff");
    begin_access(24'h000100, 1'b1, 4'h0);
    n_checks++;
    if ({DTACK_OE, cs, IOR_n, DOUT_OE} !== 7'b1_1111_10) begin
      n_errors++;
      $display("FAIL rom_rd: got %b want 1111110",
               {DTACK_OE, cs, IOR_n, DOUT_OE});
    end
    end_access();
    wait_idle("rom_rd");
  endtask

  task automatic test_berr();
    begin_access(24'h010000, 1'b1, 4'h0);
    next_edge();
    n_checks++;
    if (IOR_n !== 1'b0) begin
      n_errors++;
      $display("FAIL berr_pre: got %b want 0", IOR_n);
    end
    @(negedge CLK) BERR_n = 1'b0;
    #1;
    n_checks++;
    if ({DTACK_OE, IDEBUF_OE} !== 2'b01) begin
      n_errors++;
      $display("FAIL berr_buf: got %b want 01", {DTACK_OE, IDEBUF_OE});
    end
    next_edge();
    n_checks++;
    if ({IOR_n, DTACK_OE, busy, cs} !== 7'b101_1111) begin
      n_errors++;
      $display("FAIL berr_abort: got %b want 1011111",
               {IOR_n, DTACK_OE, busy, cs});
    end
    @(negedge CLK) BERR_n = 1'b1;
    bus_idle();
    wait_idle("berr");
    begin_access(24'h011000, 1'b1, 4'h0);
    n_checks++;
    if (cs !== 4'b1110) begin
      n_errors++;
      $display("FAIL berr_next_cs: got %b want 1110", cs);
    end
    for (int e = 1; e <= 4; e++) begin
      next_edge();
      n_checks++;
      if ({IOR_n, DTACK_OE} !== 2'b00) begin
        n_errors++;
        $display("FAIL berr_next e%0d: got %b want 00", e, {IOR_n, DTACK_OE});
      end
    end
    next_edge();
    n_checks++;
    if (DTACK_OE !== 1'b1) begin
      n_errors++;
      $display("FAIL berr_next_ack: got %b want 1", DTACK_OE);
    end
    next_edge();
    @(negedge CLK) BERR_n = 1'b0;
    #1;
    n_checks++;
    if ({DTACK_OE, OVR_OE} !== 2'b01) begin
      n_errors++;
      $display("FAIL berr_gate: got %b want 01", {DTACK_OE, OVR_OE});
    end
    @(negedge CLK) BERR_n = 1'b1;
    bus_idle();
    wait_idle("berr_gate");
  endtask

  task automatic test_reset_mid();
    begin_access(24'h008000, 1'b0, 4'b0011);
    end_access();
    wait_idle("mid_mode");
    begin_access(24'h010000, 1'b1, 4'h0);
    next_edge();
    n_checks++;
    if (IOR_n !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_pre: got %b want 0", IOR_n);
    end
    #2 RESET_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== RST_OUTS) begin
      n_errors++;
      $display("FAIL mid_outs: got %b want %b", outs, RST_OUTS);
    end
    n_checks++;
    if (DOUT !== 4'h0) begin
      n_errors++;
      $display("FAIL mid_dout: got %b want 0000", DOUT);
    end
    @(negedge CLK);
    bus_idle();
    RESET_n = 1'b1;
    next_edge();
    n_checks++;
    if ({DOUT, IDE_ROMEN, busy} !== 6'b0000_10) begin
      n_errors++;
      $display("FAIL mid_after: got %b want 000010", {DOUT, IDE_ROMEN, busy});
    end
  endtask

  initial begin
    test_reset();
    test_ch0_read();
    test_mode_ch1_write();
    test_rom_off();
    test_berr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
